// File: rtl/ddr_pkg.sv
// Shared definitions for the multiport DDR arbiter: controller command codes,
// arbiter FSM states and a small width helper.
package ddr_pkg;

   typedef logic [2:0] cmd_t;

   localparam cmd_t CMD_WRITE = 3'b000;
   localparam cmd_t CMD_READ  = 3'b001;
   localparam cmd_t CMD_NOP   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CMD   = 2'd1,
      ST_WDATA = 2'd2
   } state_t;

   // Index width that stays legal (>=1 bit) even for a single-entry range.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddr_tag_fifo.sv
// Small synchronous FIFO holding {port, word offset} tags of reads in flight;
// a push and a pop in the same cycle leave the occupancy unchanged.
module ddr_tag_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == (PTR_W + 1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   // NOTE: the tag storage has no reset; only pointers and count do, and empty gates every use of it.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ddr_multiport_arb.sv
// Round-robin arbiter sharing one DDR controller between NUM_PORTS clients:
// single-beat line writes with lane masking, tagged in-order read returns.
module ddr_multiport_arb
   import ddr_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_WIDTH      = 29,
   parameter int PORT_DATA_WIDTH = 32,
   parameter int DDR_DATA_WIDTH  = 128,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          init_calib_complete,
   input  logic [NUM_PORTS-1:0]          req_valid,
   output logic [NUM_PORTS-1:0]          req_ready,
   input  logic [NUM_PORTS-1:0]          req_we,
   input  logic [ADDR_WIDTH-1:0]         req_addr    [NUM_PORTS],
   input  logic [PORT_DATA_WIDTH-1:0]    req_wdata   [NUM_PORTS],
   input  logic [PORT_DATA_WIDTH/8-1:0]  req_byte_en [NUM_PORTS],
   output logic [NUM_PORTS-1:0]          rsp_valid,
   output logic [PORT_DATA_WIDTH-1:0]    rsp_data    [NUM_PORTS],
   output logic [DDR_DATA_WIDTH-1:0]     rsp_line    [NUM_PORTS],
   input  logic                          cmd_ready,
   output logic [2:0]                    cmd,
   output logic                          cmd_en,
   output logic [ADDR_WIDTH-1:0]         addr,
   input  logic                          wr_data_rdy,
   output logic [DDR_DATA_WIDTH-1:0]     wr_data,
   output logic                          wr_data_en,
   output logic                          wr_data_end,
   output logic [DDR_DATA_WIDTH/8-1:0]   wr_data_mask,
   input  logic [DDR_DATA_WIDTH-1:0]     rd_data,
   input  logic                          rd_data_valid,
   output logic                          err_orphan
);

   localparam int LANES   = DDR_DATA_WIDTH / PORT_DATA_WIDTH;
   localparam int LW      = clog2_min1(LANES);
   localparam int PW      = clog2_min1(NUM_PORTS);
   localparam int BE_W    = PORT_DATA_WIDTH / 8;
   localparam int OFF_LSB = $clog2(BE_W);
   localparam int TAG_W   = PW + LW;

   state_t                       state, state_nxt;
   logic [PW-1:0]                rr_ptr;
   logic                         grant_vld;
   logic [PW-1:0]                grant_idx;
   logic [PW-1:0]                lat_port;
   logic                         lat_we;
   logic [ADDR_WIDTH-1:0]        lat_addr;
   logic [PORT_DATA_WIDTH-1:0]   lat_wdata;
   logic [BE_W-1:0]              lat_be;
   logic [LW-1:0]                lat_off;
   logic [DDR_DATA_WIDTH-1:0]    wr_line;
   logic [DDR_DATA_WIDTH/8-1:0]  wr_mask;
   logic                         tag_push, tag_pop, tag_full, tag_empty;
   logic [TAG_W-1:0]             tag_dout;
   logic [PW-1:0]                head_port;
   logic [LW-1:0]                head_off;
   logic [PORT_DATA_WIDTH-1:0]   head_word;

   if (LANES > 1) begin : g_lane_off
      assign lat_off = lat_addr[OFF_LSB +: LW];
   end else begin : g_single_lane
      assign lat_off = '0;
   end

   // Round-robin search from rr_ptr; reads are skipped while the tag FIFO is full.
   always_comb begin
      logic [PW-1:0] idx;
      grant_vld = 1'b0;
      grant_idx = '0;
      idx       = '0;
      req_ready = '0;
      if (!reset && state == ST_IDLE && init_calib_complete) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            idx = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!grant_vld && req_valid[idx] && (req_we[idx] || !tag_full)) begin
               grant_vld = 1'b1;
               grant_idx = idx;
            end
         end
      end
      if (grant_vld) req_ready[grant_idx] = 1'b1;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt    = state;
      cmd          = CMD_NOP;
      cmd_en       = 1'b0;
      addr         = '0;
      tag_push     = 1'b0;
      wr_data_en   = 1'b0;
      wr_data      = '0;
      wr_data_mask = '1;
      case (state)
         ST_IDLE: if (grant_vld) state_nxt = ST_CMD;
         ST_CMD: begin
            addr = lat_addr;
            if (cmd_ready) begin
               cmd_en    = 1'b1;
               cmd       = lat_we ? CMD_WRITE : CMD_READ;
               tag_push  = !lat_we;
               state_nxt = lat_we ? ST_WDATA : ST_IDLE;
            end
         end
         ST_WDATA: begin
            wr_data      = wr_line;
            wr_data_mask = wr_mask;
            if (wr_data_rdy) begin
               wr_data_en = 1'b1;
               state_nxt  = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign wr_data_end = wr_data_en;

   always_comb begin
      wr_line = '0;
      wr_mask = '1;
      for (int l = 0; l < LANES; l++) begin
         if (lat_off == LW'(l)) begin
            wr_line[l*PORT_DATA_WIDTH +: PORT_DATA_WIDTH] = lat_wdata;
            wr_mask[l*BE_W +: BE_W]                       = ~lat_be;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         rr_ptr    <= '0;
         lat_port  <= '0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else begin
         state <= state_nxt;
         if (grant_vld) begin
            rr_ptr    <= (grant_idx == PW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            lat_port  <= grant_idx;
            lat_we    <= req_we[grant_idx];
            lat_addr  <= req_addr[grant_idx];
            lat_wdata <= req_wdata[grant_idx];
            lat_be    <= req_byte_en[grant_idx];
         end
      end
   end

   ddr_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tag_push),
      .din   ({lat_port, lat_off}),
      .pop   (tag_pop),
      .dout  (tag_dout),
      .full  (tag_full),
      .empty (tag_empty)
   );

   assign tag_pop   = rd_data_valid && !tag_empty;
   assign head_port = tag_dout[TAG_W-1 -: PW];
   assign head_off  = tag_dout[LW-1:0];

   always_comb begin
      head_word = '0;
      for (int l = 0; l < LANES; l++) begin
         if (head_off == LW'(l)) head_word = rd_data[l*PORT_DATA_WIDTH +: PORT_DATA_WIDTH];
      end
   end

   // Read returns run beside the FSM; an untagged beat is dropped and flagged.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_valid  <= '0;
         err_orphan <= 1'b0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_data[p] <= '0;
            rsp_line[p] <= '0;
         end
      end else begin
         rsp_valid <= '0;
         if (rd_data_valid) begin
            if (tag_empty) begin
               err_orphan <= 1'b1;
            end else begin
               rsp_valid[head_port] <= 1'b1;
               rsp_data[head_port]  <= head_word;
               rsp_line[head_port]  <= rd_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_ddr_multiport_arb.sv
// Directed bench for ddr_multiport_arb: a table of single-request vectors plus
// hand-written sequences for arbitration order, back-pressure and read-return corners.
module tb_ddr_multiport_arb;

   localparam int NP  = 4;
   localparam int AW  = 29;
   localparam int PDW = 32;
   localparam int DDW = 128;
   localparam int MO  = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            init_calib_complete;
   logic [NP-1:0]   req_valid, req_ready, req_we, rsp_valid;
   logic [AW-1:0]   req_addr    [NP];
   logic [PDW-1:0]  req_wdata   [NP];
   logic [3:0]      req_byte_en [NP];
   logic [PDW-1:0]  rsp_data    [NP];
   logic [DDW-1:0]  rsp_line    [NP];
   logic            cmd_ready, cmd_en, wr_data_rdy, wr_data_en, wr_data_end;
   logic            rd_data_valid, err_orphan;
   logic [2:0]      cmd;
   logic [AW-1:0]   addr;
   logic [DDW-1:0]  wr_data, rd_data;
   logic [15:0]     wr_data_mask;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   ddr_multiport_arb #(
      .NUM_PORTS       (NP),
      .ADDR_WIDTH      (AW),
      .PORT_DATA_WIDTH (PDW),
      .DDR_DATA_WIDTH  (DDW),
      .MAX_OUTSTANDING (MO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .init_calib_complete (init_calib_complete),
      .req_valid           (req_valid),
      .req_ready           (req_ready),
      .req_we              (req_we),
      .req_addr            (req_addr),
      .req_wdata           (req_wdata),
      .req_byte_en         (req_byte_en),
      .rsp_valid           (rsp_valid),
      .rsp_data            (rsp_data),
      .rsp_line            (rsp_line),
      .cmd_ready           (cmd_ready),
      .cmd                 (cmd),
      .cmd_en              (cmd_en),
      .addr                (addr),
      .wr_data_rdy         (wr_data_rdy),
      .wr_data             (wr_data),
      .wr_data_en          (wr_data_en),
      .wr_data_end         (wr_data_end),
      .wr_data_mask        (wr_data_mask),
      .rd_data             (rd_data),
      .rd_data_valid       (rd_data_valid),
      .err_orphan          (err_orphan)
   );

   typedef struct {
      logic          we;
      int            port;
      logic [AW-1:0] a;
      logic [31:0]   wdata;
      logic [3:0]    be;
      logic [127:0]  beat;      // read beat returned by the controller
      logic [127:0]  exp_line;  // expected wr_data (write) or rsp_line (read)
      logic [15:0]   exp_mask;
      logic [31:0]   exp_word;  // expected rsp_data (read)
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [NP-1:0] onehot(input int p);
      logic [NP-1:0] r;
      r = '0;
      r[p] = 1'b1;
      return r;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      req_valid = '0; rd_data_valid = 1'b0; cmd_ready = 1'b1;
      wr_data_rdy = 1'b0; init_calib_complete = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          order[$];
      int          exp_order[5];
      int          ngr, nrsp, n_en;
      logic        prev;
      logic [127:0] line_a, line_b, l1, l3;

      vecs[0] = '{we:1'b1, port:2, a:29'h0000_0008, wdata:32'hDEADBEEF, be:4'b0011, beat:'0,
                  exp_line:128'h00000000_DEADBEEF_00000000_00000000, exp_mask:16'hFCFF, exp_word:'0};
      vecs[1] = '{we:1'b1, port:0, a:29'h0000_0100, wdata:32'h12345678, be:4'b1111, beat:'0,
                  exp_line:128'h00000000_00000000_00000000_12345678, exp_mask:16'hFFF0, exp_word:'0};
      vecs[2] = '{we:1'b1, port:3, a:29'h0000_004C, wdata:32'hCAFEF00D, be:4'b1000, beat:'0,
                  exp_line:128'hCAFEF00D_00000000_00000000_00000000, exp_mask:16'h7FFF, exp_word:'0};
      vecs[3] = '{we:1'b1, port:1, a:29'h1FFF_FFF4, wdata:32'hA5A5A5A5, be:4'b0101, beat:'0,
                  exp_line:128'h00000000_00000000_A5A5A5A5_00000000, exp_mask:16'hFFAF, exp_word:'0};
      vecs[4] = '{we:1'b0, port:1, a:29'h0000_0004, wdata:'0, be:'0,
                  beat:128'h33333333_22222222_11111111_00000000,
                  exp_line:128'h33333333_22222222_11111111_00000000, exp_mask:'0, exp_word:32'h11111111};
      vecs[5] = '{we:1'b0, port:3, a:29'h0000_000C, wdata:'0, be:'0,
                  beat:128'h01234567_89ABCDEF_FEDCBA98_76543210,
                  exp_line:128'h01234567_89ABCDEF_FEDCBA98_76543210, exp_mask:'0, exp_word:32'h01234567};
      vecs[6] = '{we:1'b0, port:0, a:29'h0000_0008, wdata:'0, be:'0,
                  beat:128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000,
                  exp_line:128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000, exp_mask:'0, exp_word:32'hCCCC0002};

      reset = 1'b1; init_calib_complete = 1'b0; cmd_ready = 1'b1; wr_data_rdy = 1'b0;
      rd_data_valid = 1'b0; rd_data = '0; req_valid = '0; req_we = '0;
      for (int p = 0; p < NP; p++) begin
         req_addr[p] = '0; req_wdata[p] = '0; req_byte_en[p] = '0;
      end

      // Reset values
      repeat (3) @(negedge clk);
      #1;
      check("rst_cmd", cmd, 3'b111);
      check("rst_cmd_en", cmd_en, 1'b0);
      check("rst_wr_en", {wr_data_en, wr_data_end}, 2'b00);
      check("rst_wr_data", wr_data, '0);
      check("rst_wr_mask", wr_data_mask, 16'hFFFF);
      check("rst_addr", addr, '0);
      check("rst_req_ready", req_ready, '0);
      check("rst_rsp_valid", rsp_valid, '0);
      check("rst_rsp_data0", rsp_data[0], '0);
      check("rst_rsp_line3", rsp_line[3], '0);
      check("rst_err_orphan", err_orphan, 1'b0);

      // No grant before calibration completes
      reset = 1'b0; req_valid = 4'b0100;
      #1 check("no_calib_ready", req_ready, '0);
      @(negedge clk); #1;
      check("no_calib_ready2", req_ready, '0);
      check("no_calib_cmd_en", cmd_en, 1'b0);
      init_calib_complete = 1'b1;
      #1 check("calib_grant", req_ready, 4'b0100);
      req_valid = '0;

      // Round robin: all four ports hold reads; each beat returned right after its command
      do_reset();
      req_valid = 4'b1111; req_we = '0;
      prev = 1'b0;
      for (int c = 0; c < 12; c++) begin
         rd_data_valid = prev; rd_data = {4{32'(c)}};
         #1;
         for (int p = 0; p < NP; p++) if (req_ready[p]) order.push_back(p);
         prev = cmd_en;
         @(negedge clk);
      end
      req_valid = '0; rd_data_valid = 1'b0;
      exp_order = '{0, 1, 2, 3, 0};
      check("rr_num_grants", (order.size() >= 5), 1'b1);
      for (int i = 0; i < 5; i++)
         check($sformatf("rr_order_%0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);

      // Table-driven single requests
      do_reset();
      for (int v = 0; v < 7; v++) begin
         @(negedge clk);
         req_valid = onehot(vecs[v].port);
         req_we[vecs[v].port]      = vecs[v].we;
         req_addr[vecs[v].port]    = vecs[v].a;
         req_wdata[vecs[v].port]   = vecs[v].wdata;
         req_byte_en[vecs[v].port] = vecs[v].be;
         cmd_ready = 1'b1; wr_data_rdy = 1'b0;
         #1 check($sformatf("v%0d_ready", v), req_ready, onehot(vecs[v].port));
         @(negedge clk);
         req_valid = '0;
         #1;
         check($sformatf("v%0d_cmd_en", v), cmd_en, 1'b1);
         check($sformatf("v%0d_cmd", v), cmd, vecs[v].we ? 3'b000 : 3'b001);
         check($sformatf("v%0d_addr", v), addr, vecs[v].a);
         if (vecs[v].we) begin
            @(negedge clk); #1;
            check($sformatf("v%0d_wr_data", v), wr_data, vecs[v].exp_line);
            check($sformatf("v%0d_wr_mask", v), wr_data_mask, vecs[v].exp_mask);
            check($sformatf("v%0d_wr_hold", v), wr_data_en, 1'b0);
            wr_data_rdy = 1'b1;
            #1 check($sformatf("v%0d_wr_strobe", v), {wr_data_en, wr_data_end}, 2'b11);
            @(negedge clk);
            wr_data_rdy = 1'b0;
            #1;
            check($sformatf("v%0d_wr_done", v), wr_data_en, 1'b0);
            check($sformatf("v%0d_mask_idle", v), wr_data_mask, 16'hFFFF);
         end else begin
            @(negedge clk);
            rd_data = vecs[v].beat; rd_data_valid = 1'b1;
            @(negedge clk);
            rd_data_valid = 1'b0; rd_data = '0;
            #1;
            check($sformatf("v%0d_rsp_valid", v), rsp_valid, onehot(vecs[v].port));
            check($sformatf("v%0d_rsp_line", v), rsp_line[vecs[v].port], vecs[v].exp_line);
            check($sformatf("v%0d_rsp_data", v), rsp_data[vecs[v].port], vecs[v].exp_word);
            @(negedge clk); #1;
            check($sformatf("v%0d_rsp_pulse", v), rsp_valid, '0);
            check($sformatf("v%0d_rsp_hold", v), rsp_data[vecs[v].port], vecs[v].exp_word);
         end
      end

      // Five reads, beats held off: fifth waits for the first beat; then push+pop together
      do_reset();
      line_a = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
      line_b = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
      req_valid = 4'b0001; req_we = '0; req_addr[0] = 29'h0000_0010;
      ngr = 0;
      for (int c = 0; c < 12; c++) begin
         #1;
         if (req_ready[0]) ngr++;
         @(negedge clk);
      end
      check("mo_grants_before_beat", ngr, 4);
      #1 check("mo_fifth_held", req_ready, '0);
      rd_data = line_a; rd_data_valid = 1'b1;
      #1 check("mo_held_on_beat", req_ready, '0);
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      check("mo_rsp_valid", rsp_valid, 4'b0001);
      check("mo_rsp_line", rsp_line[0], line_a);
      check("mo_rsp_data", rsp_data[0], 32'hAAAA0000);
      check("mo_fifth_grant", req_ready, 4'b0001);
      @(negedge clk);
      rd_data = line_b; rd_data_valid = 1'b1;
      #1 check("pp_cmd_en", cmd_en, 1'b1);
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      check("pp_rsp_line", rsp_line[0], line_b);
      check("pp_grant_after", req_ready, 4'b0001);
      @(negedge clk);
      @(negedge clk);
      #1 check("pp_refull", req_ready, '0);
      req_valid = '0;
      check("pp_no_orphan_yet", err_orphan, 1'b0);
      nrsp = 0;
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         rd_data = {4{32'(b)}}; rd_data_valid = 1'b1;
         #1;
         if (rsp_valid[0]) nrsp++;
      end
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      if (rsp_valid[0]) nrsp++;
      check("pp_drain_count", nrsp, 4);
      check("pp_extra_orphan", err_orphan, 1'b1);

      // Reads from ports 1 then 3, beats returned in order
      do_reset();
      l1 = 128'h11110003_11110002_11110001_11110000;
      l3 = 128'h33330003_33330002_33330001_33330000;
      req_valid = 4'b1010; req_we = '0;
      req_addr[1] = 29'h0000_0004; req_addr[3] = 29'h0000_000C;
      #1 check("io_grant_p1", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = 4'b1000;
      @(negedge clk);
      #1 check("io_grant_p3", req_ready, 4'b1000);
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      rd_data = l1; rd_data_valid = 1'b1;
      @(negedge clk);
      rd_data = l3;
      #1;
      check("io_rsp1_valid", rsp_valid, 4'b0010);
      check("io_rsp1_line", rsp_line[1], l1);
      check("io_rsp1_data", rsp_data[1], 32'h11110001);
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      check("io_rsp3_valid", rsp_valid, 4'b1000);
      check("io_rsp3_line", rsp_line[3], l3);
      check("io_rsp3_data", rsp_data[3], 32'h33330003);
      check("io_rsp1_hold", rsp_line[1], l1);
      @(negedge clk); #1;
      check("io_rsp_idle", rsp_valid, '0);

      // cmd_ready low for 10 cycles in CMD; latched write must survive input changes
      do_reset();
      cmd_ready = 1'b0;
      req_valid = 4'b0100; req_we[2] = 1'b1; req_addr[2] = 29'h0000_0008;
      req_wdata[2] = 32'hDEADBEEF; req_byte_en[2] = 4'b0011;
      #1 check("bp_grant", req_ready, 4'b0100);
      n_en = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = '0; req_addr[2] = 29'h0000_01F0;
         req_wdata[2] = 32'h0; req_byte_en[2] = 4'hF;
         #1;
         if (cmd_en) n_en++;
      end
      check("bp_cmd_en_low", n_en, 0);
      cmd_ready = 1'b1;
      #1;
      check("bp_cmd_en", cmd_en, 1'b1);
      check("bp_cmd", cmd, 3'b000);
      check("bp_addr", addr, 29'h0000_0008);
      @(negedge clk); #1;
      check("bp_wr_data", wr_data, 128'h00000000_DEADBEEF_00000000_00000000);
      check("bp_wr_mask", wr_data_mask, 16'hFCFF);
      wr_data_rdy = 1'b1;
      @(negedge clk);
      wr_data_rdy = 1'b0;

      // Orphan beat with empty FIFO: sticky flag, no response, cleared by reset
      do_reset();
      #1 check("orph_pre", err_orphan, 1'b0);
      rd_data = '1; rd_data_valid = 1'b1;
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      check("orph_set", err_orphan, 1'b1);
      check("orph_no_rsp", rsp_valid, '0);
      repeat (3) @(negedge clk);
      #1 check("orph_sticky", err_orphan, 1'b1);
      do_reset();
      #1 check("orph_cleared", err_orphan, 1'b0);

      // Reset mid-operation discards the in-flight read
      req_valid = 4'b0001; req_we = '0; req_addr[0] = 29'h0;
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0; rd_data_valid = 1'b1;
      @(negedge clk);
      rd_data_valid = 1'b0;
      #1;
      check("midrst_orphan", err_orphan, 1'b1);
      check("midrst_no_rsp", rsp_valid, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
